// File: rtl/sram_frame_clear_pkg.sv
// Shared frame-buffer constants and the clear-engine state encoding.
// Used by the frame controller, the VGA fetch and the back-buffer clear engine.
package sram_frame_clear_pkg;

  localparam int unsigned FB_FRAME_WORDS = 307200;
  localparam int unsigned FB_ADDR_W      = 20;
  localparam int unsigned FB_CNT_W       = 19;

  localparam logic [FB_ADDR_W-1:0] FB_EVEN_BASE = 20'h00000;
  localparam logic [FB_ADDR_W-1:0] FB_ODD_BASE  = 20'h80000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } clr_state_e;

endpackage

// File: rtl/sram_frame_clear.sv
// Back-buffer clear engine: writes CLEAR_VALUE to every word of the buffer not
// on display, issuing a write cycle only while the SRAM arbiter grants the bus.
module sram_frame_clear
  import sram_frame_clear_pkg::*;
#(
  parameter int unsigned        ADDR_W      = 20,
  parameter int unsigned        DATA_W      = 16,
  parameter int unsigned        FRAME_WORDS = FB_FRAME_WORDS,
  parameter logic [ADDR_W-1:0]  EVEN_BASE   = ADDR_W'(FB_EVEN_BASE),
  parameter logic [ADDR_W-1:0]  ODD_BASE    = ADDR_W'(FB_ODD_BASE),
  parameter logic [DATA_W-1:0]  CLEAR_VALUE = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clear_start,
  input  logic              even_frame,
  output logic              clear_done,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic [ADDR_W-1:0] SRAM_ADDRESS,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe
);

  localparam int unsigned         CNT_W     = FB_CNT_W;
  localparam logic [CNT_W-1:0]    LAST_WORD = CNT_W'(FRAME_WORDS - 1);

  clr_state_e        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] base_q,  base_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              done_q,  done_d;
  logic              req_q,   req_d;
  logic              oe_q,    oe_d;

  // State and registered outputs; reset aborts any clear in flight.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      req_q   <= req_d;
      oe_q    <= oe_d;
    end
  end

  // Next-state logic; address and bus outputs are set up one cycle ahead.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    base_d  = base_q;
    addr_d  = addr_q;
    done_d  = done_q;
    req_d   = req_q;
    oe_d    = oe_q;

    unique case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          base_d  = even_frame ? ODD_BASE : EVEN_BASE;
          count_d = '0;
          addr_d  = base_d;
          done_d  = 1'b0;
          req_d   = 1'b1;
          oe_d    = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (bus_grant) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        // A lost grant retries the same word from SETUP without counting it.
        if (!bus_grant) begin
          state_d = ST_SETUP;
        end else if (count_q == LAST_WORD) begin
          req_d   = 1'b0;
          oe_d    = 1'b0;
          state_d = ST_DONE;
        end else begin
          count_d = count_q + CNT_W'(1);
          addr_d  = base_q + ADDR_W'(count_d);
          state_d = ST_SETUP;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write strobe follows the grant within the cycle so a revoked grant never writes.
  assign SRAM_WE_N    = ~((state_q == ST_WRITE) && bus_grant);
  assign SRAM_OE_N    = 1'b1;
  assign sram_dq_out  = CLEAR_VALUE;
  assign SRAM_ADDRESS = addr_q;
  assign sram_dq_oe   = oe_q;
  assign bus_req      = req_q;
  assign clear_done   = done_q;

endmodule

// File: doc/sram_frame_clear.md
# sram_frame_clear

Back-buffer clear engine for the double-buffered SRAM frame store. When the frame controller raises `clear_start`, it writes `CLEAR_VALUE` to every word of the buffer not being displayed. It then reports `clear_done`, after which the frame controller starts the next simulation step. It sits directly upstream of the frame controller's SRAM arbiter. It requests the SRAM bus and only drives write cycles while the arbiter grants it, so VGA fetches from the front buffer are never disturbed.

## Interface
Parameters:
- `ADDR_W`, 20, SRAM word-address width
- `DATA_W`, 16, SRAM data width
- `FRAME_WORDS`, 307200, words per buffer (640x480, one pixel per word)
- `EVEN_BASE`, 20'h00000, base address of the even buffer
- `ODD_BASE`, 20'h80000, base address of the odd buffer
- `CLEAR_VALUE`, 16'h0000, word written to every location

Ports:
- `Clk`  in  1  system clock (50 MHz); the only clock
- `Reset`  in  1  asynchronous, active-low reset
- `clear_start`  in  1  one-cycle request to clear the back buffer
- `even_frame`  in  1  1 = even buffer is displayed (clear odd); 0 = clear even
- `clear_done`  out  1  level; high from completion until the next accepted `clear_start`
- `bus_req`  out  1  SRAM bus request to the arbiter
- `bus_grant`  in  1  arbiter grant; may drop on any cycle
- `SRAM_ADDRESS`  out  ADDR_W  write address
- `SRAM_WE_N`  out  1  write enable, active low
- `SRAM_OE_N`  out  1  output enable, active low; held high by this block
- `sram_dq_out`  out  DATA_W  write data, routed by the top level onto `SRAM_DQ`
- `sram_dq_oe`  out  1  tristate enable for `SRAM_DQ`

## Operation
- FSM states are IDLE, SETUP, WRITE and DONE.
- IDLE:
  - `clear_start`=1 latches the base address: ODD_BASE if `even_frame`=1, else EVEN_BASE.
  - Zeroes the word counter, clears `clear_done`, sets `bus_req`, and goes to SETUP.
- SETUP:
  - Drives `SRAM_ADDRESS`=base+count, `sram_dq_out`=CLEAR_VALUE, `sram_dq_oe`=1, `SRAM_WE_N`=1.
  - Goes to WRITE if `bus_grant`=1 this cycle; otherwise stays in SETUP.
- WRITE:
  - Holds the same address and data. `SRAM_WE_N` is combinational: `SRAM_WE_N = ~(state==WRITE && bus_grant)`.
  - If `bus_grant`=0 this cycle, the word is not counted and the FSM returns to SETUP at the same address (retry).
  - If `bus_grant`=1 and count==FRAME_WORDS-1, go to DONE.
  - If `bus_grant`=1 otherwise, count+1 and go to SETUP.
- DONE: drops `bus_req` and `sram_dq_oe`, sets `clear_done`=1, goes to IDLE.
- Address arithmetic is base+count, ADDR_W bits, unsigned. The counter is 19 bits and saturates logically at FRAME_WORDS-1; it never wraps into the other buffer.
- `clear_start` outside IDLE is ignored. `even_frame` is sampled only at start; later changes have no effect on a clear in progress.
- `SRAM_OE_N` is always 1.
- `sram_dq_oe`=1 only in SETUP and WRITE.

## Timing
- Reset values: `clear_done`=0, `bus_req`=0, `SRAM_WE_N`=1, `SRAM_OE_N`=1, `sram_dq_oe`=0, `SRAM_ADDRESS`=0, `sram_dq_out`=CLEAR_VALUE, state IDLE, count 0.
- Reset asserted mid-clear aborts immediately:
  - All outputs return to their reset values asynchronously.
  - No partial write is completed.
  - `clear_done` stays 0 until a new full clear finishes.
- Each word takes 2 cycles: a SETUP cycle with address and data stable, then WRITE with WE_N low for 20 ns. Address and data are held through the rising edge that ends WRITE.
- With continuous grant, a clear takes 2*FRAME_WORDS+2 cycles from the `clear_start` edge to `clear_done` high: 1 cycle IDLE→SETUP, 2 per word, 1 in DONE.
- Every cycle of `bus_grant`=0 adds one stall cycle in SETUP, or one retry cost in WRITE.
- `bus_req` is high from the cycle after `clear_start` through the last WRITE cycle, and low in DONE.
- `clear_start` arriving in the same cycle DONE→IDLE is ignored; it is accepted only in IDLE.

## Structure
- A shared frame-buffer package holds:
  - FRAME_WORDS, EVEN_BASE and ODD_BASE, which are also used by the frame controller and VGA fetch.
  - The FSM state enum.
- Single module, no sub-modules. The top level owns the `SRAM_DQ` tristate and the arbiter mux.

## Test plan
Run with FRAME_WORDS=4.
- Reset low, then high; pulse `clear_start` with `even_frame`=1 and grant held at 1:
  - Writes occur to 0x80000..0x80003 with data 0x0000.
  - `SRAM_WE_N` is low exactly 4 cycles.
  - `clear_done` rises 10 cycles after the start edge.
- `even_frame`=0: addresses are 0x00000..0x00003, and `even_frame` toggled mid-clear does not change them.
- Grant dropped during the WRITE of word 1: that WE_N pulse is suppressed, 0x80001 is rewritten once, total writes = 4, `clear_done` is delayed by 2 cycles.
- Grant held low 5 cycles in SETUP: address is stable, WE_N=1 throughout, then normal completion.
- `clear_start` pulsed during a clear: ignored. Afterwards `clear_done` stays 1 until a new start in IDLE, which drops it the next cycle.
- Reset asserted after 2 words: all outputs reach their reset values within the same cycle. A subsequent start rewrites all 4 words.
